pmp_csr: RTL

PMP_CSR -- requirements
Module: pmp_csr

---
 rtl/pmp_csr.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pmp_csr.sv
// pmp_csr: PMP configuration/address CSR storage with a sequential decoder.
//
// Stores NUM_PMP cfg bytes and NUM_PMP word addresses (bits [NPHYS-1:2]).
// Any write that actually changes storage starts a scan. The scan decodes one
// entry per clock into staging registers. All registered pmp_* outputs are then
// replaced in a single cycle, so consumers never see a half-updated table.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   csr_wr          write strobe
//   csr_sel         0 = cfg entry, 1 = addr entry
//   csr_idx         entry index (>= NUM_PMP: write ignored, read returns 0)
//   csr_wdata       write data (cfg in [7:0], addr in [NPHYS-3:0])
//   csr_rdata       combinational, zero-extended read of the selected entry
//   busy            high while a decode scan is in progress
//   pmp_start/aend  decoded inclusive word-address range per entry
//   pmp_prot        {X,W,R} per entry
//   pmp_valid       entry matches something
//   pmp_locked      entry L bit
module pmp_csr #(
   parameter int NPHYS   = 56,
   parameter int NUM_PMP = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          csr_wr,
   input  logic                          csr_sel,
   input  logic [3:0]                    csr_idx,
   input  logic [63:0]                   csr_wdata,
   output logic [63:0]                   csr_rdata,
   output logic                          busy,
   output logic [NUM_PMP-1:0][NPHYS-3:0] pmp_start,
   output logic [NUM_PMP-1:0][NPHYS-3:0] pmp_aend,
   output logic [NUM_PMP-1:0][2:0]       pmp_prot,
   output logic [NUM_PMP-1:0]            pmp_valid,
   output logic [NUM_PMP-1:0]            pmp_locked
);
   localparam int         AW       = NPHYS - 2;
   localparam logic [3:0] LAST_IDX = 4'(NUM_PMP - 1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t     state_reg, state_next;
   logic [3:0] scan_idx_reg, scan_idx_next;

   logic [NUM_PMP-1:0][7:0]    cfg_reg;
   logic [NUM_PMP-1:0][AW-1:0] addr_reg;
   logic [NUM_PMP-1:0][AW-1:0] prev_addr;
   logic [NUM_PMP-1:0]         cfg_change;
   logic [NUM_PMP-1:0]         addr_change;
   logic [7:0]                 cfg_wdata;
   logic                       restart;
   logic                       decode_en;
   logic                       commit;

   logic [NUM_PMP-1:0][AW-1:0] stg_start_reg, stg_start_next;
   logic [NUM_PMP-1:0][AW-1:0] stg_aend_reg, stg_aend_next;
   logic [NUM_PMP-1:0][2:0]    stg_prot_reg, stg_prot_next;
   logic [NUM_PMP-1:0]         stg_valid_reg, stg_valid_next;
   logic [NUM_PMP-1:0]         stg_locked_reg, stg_locked_next;

   // Fields of the entry currently being decoded
   logic [1:0]    sc_mode;
   logic [2:0]    sc_prot;
   logic          sc_lock;
   logic [AW-1:0] sc_addr, sc_prev;

   logic [AW-1:0] dec_start, dec_aend, napot_mask;
   logic          dec_valid;

   // Legalised cfg byte: W without R is not allowed, bits 6:5 are reserved
   assign cfg_wdata = {csr_wdata[7], 2'b00, csr_wdata[4:3], csr_wdata[2],
                       csr_wdata[1] & csr_wdata[0], csr_wdata[0]};

   if (AW < 64) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^csr_wdata[63:AW];
   end

   for (genvar gi = 0; gi < NUM_PMP; gi++) begin : g_entry
      logic hit;
      logic tor_lock_above;

      // A locked entry swallows every write aimed at it
      assign hit = csr_wr && (csr_idx == 4'(gi)) && !cfg_reg[gi][7];

      // A locked TOR entry above also freezes this entry's address, because that address is its base
      if (gi + 1 < NUM_PMP) begin : g_above
         assign tor_lock_above = cfg_reg[gi+1][7] && (cfg_reg[gi+1][4:3] == 2'd1);
      end else begin : g_top
         assign tor_lock_above = 1'b0;
      end

      if (gi == 0) begin : g_prev0
         assign prev_addr[gi] = '0;
      end else begin : g_prevn
         assign prev_addr[gi] = addr_reg[gi-1];
      end

      // Only writes that really alter the stored value count; rewrites of the same value are silent
      assign cfg_change[gi]  = hit && !csr_sel && (cfg_wdata != cfg_reg[gi]);
      assign addr_change[gi] = hit && csr_sel && !tor_lock_above &&
                               (csr_wdata[AW-1:0] != addr_reg[gi]);

      wire stg_hit = decode_en && (scan_idx_reg == 4'(gi));
      assign stg_start_next[gi]  = stg_hit ? dec_start : stg_start_reg[gi];
      assign stg_aend_next[gi]   = stg_hit ? dec_aend  : stg_aend_reg[gi];
      assign stg_prot_next[gi]   = stg_hit ? sc_prot   : stg_prot_reg[gi];
      assign stg_valid_next[gi]  = stg_hit ? dec_valid : stg_valid_reg[gi];
      assign stg_locked_next[gi] = stg_hit ? sc_lock   : stg_locked_reg[gi];
   end

   assign restart = (|cfg_change) || (|addr_change);
   // A restarting write wins over the decode on the same edge; every staging
   // entry is rewritten before the next commit, so stale staging is never exposed.
   assign decode_en = (state_reg == SCAN) && !restart;
   assign commit    = decode_en && (scan_idx_reg == LAST_IDX);

   // CSR storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_reg  <= '0;
         addr_reg <= '0;
      end else begin
         for (int i = 0; i < NUM_PMP; i++) begin
            if (cfg_change[i])  cfg_reg[i]  <= cfg_wdata;
            if (addr_change[i]) addr_reg[i] <= csr_wdata[AW-1:0];
         end
      end
   end

   // Select the entry under decode
   always_comb begin
      sc_mode = 2'd0;
      sc_prot = 3'd0;
      sc_lock = 1'b0;
      sc_addr = '0;
      sc_prev = '0;
      for (int i = 0; i < NUM_PMP; i++) begin
         if (scan_idx_reg == 4'(i)) begin
            sc_mode = cfg_reg[i][4:3];
            sc_prot = cfg_reg[i][2:0];
            sc_lock = cfg_reg[i][7];
            sc_addr = addr_reg[i];
            sc_prev = prev_addr[i];
         end
      end
   end

   // Range decode, all arithmetic wrapping at AW bits
   always_comb begin
      dec_start  = '0;
      dec_aend   = '0;
      dec_valid  = 1'b0;
      napot_mask = sc_addr ^ (sc_addr + AW'(1));
      case (sc_mode)
         2'd1: begin
            dec_start = sc_prev;
            dec_aend  = sc_addr - AW'(1);
            dec_valid = sc_addr > sc_prev;
         end
         2'd2: begin
            dec_start = sc_addr;
            dec_aend  = sc_addr;
            dec_valid = 1'b1;
         end
         2'd3: begin
            dec_start = sc_addr & ~napot_mask;
            dec_aend  = sc_addr | napot_mask;
            dec_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Staging and atomic output commit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stg_start_reg  <= '0;
         stg_aend_reg   <= '0;
         stg_prot_reg   <= '0;
         stg_valid_reg  <= '0;
         stg_locked_reg <= '0;
         pmp_start      <= '0;
         pmp_aend       <= '0;
         pmp_prot       <= '0;
         pmp_valid      <= '0;
         pmp_locked     <= '0;
      end else begin
         stg_start_reg  <= stg_start_next;
         stg_aend_reg   <= stg_aend_next;
         stg_prot_reg   <= stg_prot_next;
         stg_valid_reg  <= stg_valid_next;
         stg_locked_reg <= stg_locked_next;
         if (commit) begin
            pmp_start  <= stg_start_next;
            pmp_aend   <= stg_aend_next;
            pmp_prot   <= stg_prot_next;
            pmp_valid  <= stg_valid_next;
            pmp_locked <= stg_locked_next;
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         scan_idx_reg <= '0;
      end else begin
         state_reg    <= state_next;
         scan_idx_reg <= scan_idx_next;
      end
   end

   // FSM: next state
   always_comb begin
      state_next    = state_reg;
      scan_idx_next = scan_idx_reg;
      if (restart) begin
         state_next    = SCAN;
         scan_idx_next = '0;
      end else if (state_reg == SCAN) begin
         if (scan_idx_reg == LAST_IDX) begin
            state_next    = IDLE;
            scan_idx_next = '0;
         end else begin
            scan_idx_next = scan_idx_reg + 4'd1;
         end
      end
   end

   // FSM: outputs
   always_comb begin
      busy = (state_reg == SCAN);
   end

   // CSR read
   always_comb begin
      csr_rdata = '0;
      for (int i = 0; i < NUM_PMP; i++) begin
         if (csr_idx == 4'(i)) begin
            csr_rdata = csr_sel ? 64'(addr_reg[i]) : 64'(cfg_reg[i]);
         end
      end
   end

endmodule
